// File: rtl/ps2_rx_mmio.sv
// ps2_rx_mmio -- memory-mapped PS/2 keyboard receiver.
//
// Deserializes device-to-host PS/2 frames (start, 8 data bits LSB first,
// odd parity, stop). It checks framing and parity, and buffers good
// scancodes in a FIFO. The CPU polls and pops the FIFO through the shared
// data-memory bus.
//
// Optional feature macro: PS2_RX_TIMEOUT_EN
//   When defined, a partial frame is aborted after TIMEOUT_CYCLES idle
//   clock cycles and frame_err is raised. When undefined, no counter is
//   built and a stalled frame waits for more edges, or for reset.
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-low reset
//   ps2_clk    raw PS/2 clock pin (asynchronous)
//   ps2_data   raw PS/2 data pin (asynchronous)
//   mem_addr   CPU data address
//   mem_wen    CPU store strobe
//   mem_wdata  CPU store data (only the strobe matters)
//   rdata      read data for DATA/STATUS, 0 otherwise
//   rsel       high when mem_addr hits DATA_ADDR or STATUS_ADDR
module ps2_rx_mmio #(
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [31:0] DATA_ADDR      = 32'd4099,
  parameter logic [31:0] STATUS_ADDR    = 32'd4100,
  parameter int          TIMEOUT_CYCLES = 5000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [31:0] mem_addr,
  input  logic        mem_wen,
  input  logic [31:0] mem_wdata,
  output logic [31:0] rdata,
  output logic        rsel
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_next;
  logic          clk_meta, clk_sync, clk_prev, data_meta, data_sync;
  logic          fall;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          parity_bit;
  logic          frame_end, frame_good, frame_bad, timeout_hit;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full, pop_req, pop_eff, push, clear_flags;
  logic          overrun, frame_err;
  logic          unused_bits;

  // The store data is only a strobe, and the timeout length is unused in
  // builds without the timeout.
  assign unused_bits = ^{mem_wdata, 32'(TIMEOUT_CYCLES)};

  // Synchronizers idle high so that reset never fakes a falling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
      fall      <= 1'b0;
    end else begin
      clk_meta  <= ps2_clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2_data;
      data_sync <= data_meta;
      fall      <= clk_prev & ~clk_sync;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // A high data line at a falling edge in IDLE is not a start bit, so it is
  // ignored. The timeout only fires on a cycle with no edge.
  always_comb begin
    state_next = state;
    frame_end  = 1'b0;
    case (state)
      IDLE:   if (fall && !data_sync) state_next = DATA;
      DATA:   if (fall && bit_cnt == 3'd7) state_next = PARITY;
      PARITY: if (fall) state_next = STOP;
      STOP:   if (fall) begin
                state_next = IDLE;
                frame_end  = 1'b1;
              end
      default: state_next = IDLE;
    endcase
    if (timeout_hit) state_next = IDLE;
  end

  // At the stop edge, data_sync holds the stop bit.
  assign frame_good = frame_end && (^{shreg, parity_bit}) && data_sync;
  assign frame_bad  = frame_end && !frame_good;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;

  assign timeout_hit = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // Counts cycles since the last falling edge while a frame is in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                  tcnt <= '0;
    else if (fall || state == IDLE || timeout_hit) tcnt <= '0;
    else                                         tcnt <= tcnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Shift register, bit counter and parity capture. The data bits arrive
  // LSB first, so each bit enters at bit 7 and the register shifts right.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
    end else if (timeout_hit) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
    end else if (fall) begin
      case (state)
        IDLE: if (!data_sync) begin
                shreg   <= '0;
                bit_cnt <= '0;
              end
        DATA: begin
                shreg   <= {data_sync, shreg[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
              end
        PARITY: parity_bit <= data_sync;
        default: ;
      endcase
    end
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO with a
  // simultaneous pop is accepted and does not count as an overrun.
  assign empty       = (count == '0);
  assign full        = (count == CW'(FIFO_DEPTH));
  assign pop_req     = mem_wen && (mem_addr == DATA_ADDR);
  assign pop_eff     = pop_req && !empty;
  assign push        = frame_good && (!full || pop_eff);
  assign clear_flags = mem_wen && (mem_addr == STATUS_ADDR);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop_eff);
    end
  end

  // Sticky error flags. When a set and a clear coincide, the set wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (frame_good && full && !pop_eff) overrun <= 1'b1;
      else if (clear_flags)               overrun <= 1'b0;
      if (frame_bad || timeout_hit)       frame_err <= 1'b1;
      else if (clear_flags)               frame_err <= 1'b0;
    end
  end

  // Zero-latency read path for the q_dmem mux. The head is masked when the
  // FIFO is empty, so an empty DATA read returns 0.
  always_comb begin
    rdata = '0;
    rsel  = 1'b0;
    if (mem_addr == DATA_ADDR) begin
      rsel  = 1'b1;
      rdata = {23'b0, !empty, empty ? 8'h00 : mem[rd_ptr]};
    end else if (mem_addr == STATUS_ADDR) begin
      rsel  = 1'b1;
      rdata = {14'b0, frame_err, overrun, {(16 - CW){1'b0}}, count};
    end
  end

endmodule

// File: tb/tb_ps2_rx_mmio.sv
// tb_ps2_rx_mmio -- directed self-checking bench for ps2_rx_mmio.
//
// Drives PS/2 frames on the pins with a short bit period (40 clock cycles
// per bit). It reads and writes the DATA and STATUS registers through the
// memory bus and compares the results against hand-computed values.
module tb_ps2_rx_mmio;

  localparam logic [31:0] DATA_A   = 32'd4099;
  localparam logic [31:0] STATUS_A = 32'd4100;

  logic        clock;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] rdata;
  logic        rsel;

  int checks = 0;
  int errors = 0;

  ps2_rx_mmio dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .mem_addr (mem_addr),
    .mem_wen  (mem_wen),
    .mem_wdata(mem_wdata),
    .rdata    (rdata),
    .rsel     (rsel)
  );

  // 50 MHz system clock.
  initial clock = 1'b0;
  always #10 clock = ~clock;

  // One PS/2 bit. Data is set while the clock is high, then the clock is
  // held low for 20 cycles. With pop_at_fall, a DATA pop store is placed on
  // the cycle where the DUT acts on this falling edge. That cycle is three
  // posedges after the fall is detected on the pin, so the store lands on
  // the fourth posedge.
  task automatic ps2_bit(input logic b, input logic pop_at_fall);
    ps2_data = b;
    repeat (10) @(negedge clock);
    ps2_clk = 1'b0;
    if (pop_at_fall) begin
      repeat (3) @(negedge clock);
      mem_addr = DATA_A;
      mem_wen  = 1'b1;
      @(negedge clock);
      mem_wen  = 1'b0;
      repeat (16) @(negedge clock);
    end else begin
      repeat (20) @(negedge clock);
    end
    ps2_clk = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  // Full frame. Odd parity is ~^d; bad_parity flips it.
  task automatic send_frame(input logic [7:0] d, input logic bad_parity, input logic pop_at_stop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0);
    ps2_bit((~^d) ^ bad_parity, 1'b0);
    ps2_bit(1'b1, pop_at_stop);
    ps2_data = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d, output logic s);
    @(negedge clock);
    mem_addr = a;
    mem_wen  = 1'b0;
    #1;
    d = rdata;
    s = rsel;
  endtask

  task automatic store(input logic [31:0] a);
    @(negedge clock);
    mem_addr  = a;
    mem_wdata = 32'hDEAD_BEEF;
    mem_wen   = 1'b1;
    @(negedge clock);
    mem_wen   = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        s;
    reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    mem_addr = '0; mem_wen = 1'b0; mem_wdata = '0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    read_reg(DATA_A, d, s);
    checks++;
    if (d !== 32'h0 || s !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_data: got %h sel %b, expected 00000000 sel 1", d, s);
    end
    read_reg(STATUS_A, d, s);
    checks++;
    if (d !== 32'h0 || s !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_status: got %h sel %b, expected 00000000 sel 1", d, s);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] d;
    logic        s;
    send_frame(8'h1C, 1'b0, 1'b0);
    read_reg(DATA_A, d, s);
    checks++;
    if (d !== 32'h0000011C) begin
      errors++; $display("[TB] FAIL single_data: got %h expected 0000011c", d);
    end
    read_reg(STATUS_A, d, s);
    checks++;
    if (d !== 32'h00000001) begin
      errors++; $display("[TB] FAIL single_status: got %h expected 00000001", d);
    end
    read_reg(32'd4098, d, s);
    checks++;
    if (d !== 32'h0 || s !== 1'b0) begin
      errors++; $display("[TB] FAIL unmapped: got %h sel %b, expected 00000000 sel 0", d, s);
    end
    store(DATA_A);
    read_reg(DATA_A, d, s);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("[TB] FAIL single_pop: got %h expected 00000000", d);
    end
  endtask

  task automatic test_parity_error();
    logic [31:0] d;
    logic        s;
    send_frame(8'h1C, 1'b1, 1'b0);
    read_reg(STATUS_A, d, s);
    checks++;
    if (d !== 32'h00020000) begin
      errors++; $display("[TB] FAIL parity_status: got %h expected 00020000", d);
    end
    store(STATUS_A);
    read_reg(STATUS_A, d, s);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("[TB] FAIL parity_clear: got %h expected 00000000", d);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic        s;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    read_reg(STATUS_A, d, s);
    checks++;
    if (d !== 32'h00010008) begin
      errors++; $display("[TB] FAIL overrun_status: got %h expected 00010008", d);
    end
    for (int i = 1; i <= 8; i++) begin
      read_reg(DATA_A, d, s);
      checks++;
      if (d !== (32'h100 | 32'(i))) begin
        errors++; $display("[TB] FAIL overrun_pop%0d: got %h expected %h", i, d, 32'h100 | 32'(i));
      end
      store(DATA_A);
    end
    read_reg(DATA_A, d, s);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("[TB] FAIL overrun_empty: got %h expected 00000000", d);
    end
    store(STATUS_A);
    read_reg(STATUS_A, d, s);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("[TB] FAIL overrun_clear: got %h expected 00000000", d);
    end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d;
    logic        s;
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    read_reg(STATUS_A, d, s);
    checks++;
    if (d !== 32'h00000008) begin
      errors++; $display("[TB] FAIL pushpop_status: got %h expected 00000008", d);
    end
    read_reg(DATA_A, d, s);
    checks++;
    if (d !== 32'h00000112) begin
      errors++; $display("[TB] FAIL pushpop_head: got %h expected 00000112", d);
    end
    for (int i = 0; i < 7; i++) store(DATA_A);
    read_reg(DATA_A, d, s);
    checks++;
    if (d !== 32'h00000155) begin
      errors++; $display("[TB] FAIL pushpop_last: got %h expected 00000155", d);
    end
    store(DATA_A);
    read_reg(STATUS_A, d, s);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("[TB] FAIL pushpop_drain: got %h expected 00000000", d);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    logic        s;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    repeat (6000) @(negedge clock);
    read_reg(STATUS_A, d, s);
    checks++;
`ifdef PS2_RX_TIMEOUT_EN
    if (d !== 32'h00020000) begin
      errors++; $display("[TB] FAIL timeout_status: got %h expected 00020000", d);
    end
    store(STATUS_A);
`else
    if (d !== 32'h0) begin
      errors++; $display("[TB] FAIL stall_status: got %h expected 00000000", d);
    end
    pulse_reset();
`endif
    send_frame(8'hF0, 1'b0, 1'b0);
    read_reg(DATA_A, d, s);
    checks++;
    if (d !== 32'h000001F0) begin
      errors++; $display("[TB] FAIL timeout_next: got %h expected 000001f0", d);
    end
    read_reg(STATUS_A, d, s);
    checks++;
    if (d !== 32'h00000001) begin
      errors++; $display("[TB] FAIL timeout_next_status: got %h expected 00000001", d);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    logic        s;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'(i & 1), 1'b0);
    ps2_data = 1'b1;
    pulse_reset();
    send_frame(8'h1C, 1'b0, 1'b0);
    read_reg(DATA_A, d, s);
    checks++;
    if (d !== 32'h0000011C) begin
      errors++; $display("[TB] FAIL midreset_data: got %h expected 0000011c", d);
    end
    read_reg(STATUS_A, d, s);
    checks++;
    if (d !== 32'h00000001) begin
      errors++; $display("[TB] FAIL midreset_status: got %h expected 00000001", d);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity_error();
    test_overrun();
    test_push_pop_full();
    test_timeout();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
